rs_bank: RTL and testbench
==========================

RS_BANK -- requirements
Module: rs_bank

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter NUM_RS, default 6, entry count, fixed at 6 in this revision.
REQ-003 Ports SHALL be:
- CLK  in  1  single clock; all state on posedge.
- RST_N  in  1  reset, asynchronous, active-low.
- DISPATCH_TASK  in  task_t  task from issue queue: opcode, src1/src2 tag, value, valid, imm.
- dest_rs  in  RS_tag_type  target entry; INVALID means no dispatch this cycle.
- rs_busy  out  6  per-entry occupied flag, registered.
- cdb_valid  in  1  common data bus broadcast valid.
- cdb_tag  in  RS_tag_type  producing entry of the broadcast.
- cdb_value  in  XLEN  broadcast result.
- fu_issue_valid  out  3  per class [0]=STORE, [1]=LOAD, [2]=ALU.
- fu_issue_op  out  issue_t[3]  opcode, operand values, imm, own tag.
- fu_issue_ready  in  3  functional unit accepts this cycle.
- dispatch_err  out  1  one-cycle pulse on a rejected dispatch.

Function
REQ-004 Entry map SHALL be STORE_1=0, STORE_2=1, LOAD_1=2, LOAD_2=3, ALU_1=4, ALU_2=5; rs_busy[i] is entry i.
REQ-005 When dest_rs != INVALID and the target entry is not busy, the entry SHALL capture DISPATCH_TASK on the edge and assert busy from the next cycle.
REQ-006 Dispatch to a busy entry, including one issuing in the same cycle, SHALL be ignored and SHALL pulse dispatch_err the next cycle.
REQ-007 Each busy entry SHALL snoop the CDB every cycle: an invalid operand whose tag equals cdb_tag while cdb_valid is high SHALL take cdb_value and become valid on that edge.
REQ-008 CDB bypass SHALL apply at dispatch: a task captured in the same cycle as a matching broadcast SHALL store the operand as valid with cdb_value.
REQ-009 An entry is ready when busy and both operands are valid.
REQ-010 fu_issue_valid[c] SHALL be combinational from registered entry state. It is high iff either entry of class c is ready.
REQ-011 With both entries of a class ready, the older one by dispatch order SHALL be selected. A per-class age bit records order. On a tie from reset, the lower index is selected.
REQ-012 fu_issue_op[c] SHALL hold the selected entry's contents and tag. It SHALL be held stable while valid is high and ready is low.
REQ-013 On fu_issue_valid[c] && fu_issue_ready[c], the selected entry SHALL clear busy on that edge and lose no other entry's state.
REQ-014 A matching CDB broadcast in an entry's issue cycle SHALL NOT change the issued operands.
REQ-015 All three classes SHALL issue independently in the same cycle.
REQ-016 Latency: dispatch at cycle N with valid operands SHALL give fu_issue_valid at N+1 at the earliest. A CDB wakeup at N likewise SHALL give fu_issue_valid at N+1.
REQ-017 An opcode not matching the entry class SHALL still be accepted; class selection is by dest_rs only.

Reset
REQ-018 RST_N low SHALL asynchronously clear every busy bit, operand-valid bit, age bit and dispatch_err.
REQ-019 fu_issue_valid SHALL be 0 during reset. Entry data registers need no reset.
REQ-020 Reset asserted mid-operation SHALL discard all held tasks with no issue on the release cycle.

Structure
REQ-021 task_t, issue_t, RS_tag_type (3-bit: 0-5 entries, 7=INVALID) and the class index constants SHALL live in package cpu_types.
REQ-022 One sub-module rs_entry SHALL hold a single entry with capture, CDB snoop, ready and clear. rs_bank SHALL instantiate six rs_entry instances plus per-class select and age logic.

Verification
REQ-023 Required directed scenarios:
- ALU task to ALU_1, both operands valid (5, 7) -> rs_busy=6'b010000 next cycle; fu_issue_valid[2]=1 with operands 5, 7; ready high -> busy clears the following cycle.
- LOAD to LOAD_1 with src1 tag ALU_2 invalid; 3 cycles later CDB broadcasts ALU_2 value 0x1234 -> fu_issue_valid[1] rises the next cycle with src1=0x1234.
- Dispatch to STORE_2 in the same cycle CDB broadcasts its src2 tag value 9 -> stored valid; issues next cycle with src2=9.
- STORE_1 dispatched, then STORE_2, both ready, ready low 2 cycles then high -> STORE_1 issues first, STORE_2 on the following accept.
- Dispatch to busy LOAD_2 -> contents unchanged, dispatch_err pulses once.
- RST_N low while 4 entries are busy -> rs_busy=0 and fu_issue_valid=0 immediately, with no issue after release.

Source files
------------

// File: rtl/cpu_types.sv
// rtl/cpu_types.sv - shared reservation-station tag, task and issue types
package cpu_types;

    localparam int DATA_W      = 32;
    localparam int NUM_CLASSES = 3;

    typedef logic [2:0] RS_tag_type;
    typedef logic [5:0] opcode_t;

    localparam RS_tag_type STORE_1 = 3'd0;
    localparam RS_tag_type STORE_2 = 3'd1;
    localparam RS_tag_type LOAD_1  = 3'd2;
    localparam RS_tag_type LOAD_2  = 3'd3;
    localparam RS_tag_type ALU_1   = 3'd4;
    localparam RS_tag_type ALU_2   = 3'd5;
    localparam RS_tag_type INVALID = 3'd7;

    localparam int CLS_STORE = 0;
    localparam int CLS_LOAD  = 1;
    localparam int CLS_ALU   = 2;

    typedef struct packed {
        opcode_t           opcode;
        RS_tag_type        src1_tag;
        logic [DATA_W-1:0] src1_value;
        logic              src1_valid;
        RS_tag_type        src2_tag;
        logic [DATA_W-1:0] src2_value;
        logic              src2_valid;
        logic [DATA_W-1:0] imm;
    } task_t;

    typedef struct packed {
        opcode_t           opcode;
        logic [DATA_W-1:0] src1_value;
        logic [DATA_W-1:0] src2_value;
        logic [DATA_W-1:0] imm;
        RS_tag_type        tag;
    } issue_t;

endpackage

// File: rtl/rs_bank_if.sv
// rtl/rs_bank_if.sv - dispatch, CDB and functional-unit issue bundle for rs_bank
interface rs_bank_if #(parameter int XLEN = 32);
    import cpu_types::*;

    task_t                       DISPATCH_TASK;
    RS_tag_type                  dest_rs;
    logic                        dispatch_err;
    logic                        cdb_valid;
    RS_tag_type                  cdb_tag;
    logic [XLEN-1:0]             cdb_value;
    logic [NUM_CLASSES-1:0]      fu_issue_valid;
    issue_t [NUM_CLASSES-1:0]    fu_issue_op;
    logic [NUM_CLASSES-1:0]      fu_issue_ready;

    modport master (
        output DISPATCH_TASK, dest_rs, cdb_valid, cdb_tag, cdb_value, fu_issue_ready,
        input  dispatch_err, fu_issue_valid, fu_issue_op
    );

    modport slave (
        input  DISPATCH_TASK, dest_rs, cdb_valid, cdb_tag, cdb_value, fu_issue_ready,
        output dispatch_err, fu_issue_valid, fu_issue_op
    );

endinterface

// File: rtl/rs_entry.sv
// rtl/rs_entry.sv - one reservation-station slot: capture with CDB bypass, snoop, ready, clear
module rs_entry
    import cpu_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             dispatch_en,
    input  task_t            dispatch_task,
    input  logic             cdb_valid,
    input  RS_tag_type       cdb_tag,
    input  logic [XLEN-1:0]  cdb_value,
    input  logic             clear,
    output logic             busy,
    output logic             ready,
    output task_t            entry
);

    task_t data_q;
    logic  busy_q;
    logic  s1v_q;
    logic  s2v_q;

    logic  byp1, byp2, snp1, snp2;

    // Bypass covers a broadcast landing in the same cycle the task arrives.
    assign byp1 = cdb_valid && !dispatch_task.src1_valid && (cdb_tag == dispatch_task.src1_tag);
    assign byp2 = cdb_valid && !dispatch_task.src2_valid && (cdb_tag == dispatch_task.src2_tag);
    // No snoop while issuing so the operands handed out stay what was offered.
    assign snp1 = busy_q && !clear && !s1v_q && cdb_valid && (cdb_tag == data_q.src1_tag);
    assign snp2 = busy_q && !clear && !s2v_q && cdb_valid && (cdb_tag == data_q.src2_tag);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q <= 1'b0;
            s1v_q  <= 1'b0;
            s2v_q  <= 1'b0;
        end else begin
            if (clear)
                busy_q <= 1'b0;
            else if (dispatch_en)
                busy_q <= 1'b1;

            if (dispatch_en)
                s1v_q <= dispatch_task.src1_valid || byp1;
            else if (snp1)
                s1v_q <= 1'b1;

            if (dispatch_en)
                s2v_q <= dispatch_task.src2_valid || byp2;
            else if (snp2)
                s2v_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (dispatch_en) begin
            data_q <= dispatch_task;
            if (byp1)
                data_q.src1_value <= cdb_value;
            if (byp2)
                data_q.src2_value <= cdb_value;
        end else begin
            if (snp1)
                data_q.src1_value <= cdb_value;
            if (snp2)
                data_q.src2_value <= cdb_value;
        end
    end

    always_comb begin
        entry            = data_q;
        entry.src1_valid = s1v_q;
        entry.src2_valid = s2v_q;
    end

    assign busy  = busy_q;
    assign ready = busy_q && s1v_q && s2v_q;

endmodule

// File: rtl/rs_bank.sv
// rtl/rs_bank.sv - six-entry reservation-station bank with per-class oldest-first issue
module rs_bank
    import cpu_types::*;
#(
    parameter int XLEN   = 32,
    parameter int NUM_RS = 6
) (
    input  logic              CLK,
    input  logic              RST_N,
    rs_bank_if.slave          bus,
    output logic [NUM_RS-1:0] rs_busy
);

    logic [NUM_RS-1:0] busy;
    logic [NUM_RS-1:0] ready;
    logic [NUM_RS-1:0] disp_en;
    logic [NUM_RS-1:0] clr;
    task_t             ent [NUM_RS];

    logic disp_hit;
    logic target_busy;
    logic err_q;

    assign disp_hit    = (bus.dest_rs != INVALID) && (int'(bus.dest_rs) < NUM_RS);
    assign target_busy = disp_hit && busy[bus.dest_rs];

    for (genvar i = 0; i < NUM_RS; i++) begin : g_ent
        assign disp_en[i] = disp_hit && !busy[i] && (bus.dest_rs == RS_tag_type'(i));

        rs_entry #(.XLEN(XLEN)) u_entry (
            .CLK           (CLK),
            .RST_N         (RST_N),
            .dispatch_en   (disp_en[i]),
            .dispatch_task (bus.DISPATCH_TASK),
            .cdb_valid     (bus.cdb_valid),
            .cdb_tag       (bus.cdb_tag),
            .cdb_value     (bus.cdb_value),
            .clear         (clr[i]),
            .busy          (busy[i]),
            .ready         (ready[i]),
            .entry         (ent[i])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            err_q <= 1'b0;
        else
            err_q <= target_busy;
    end

    assign bus.dispatch_err = err_q;
    assign rs_busy          = busy;

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cls
        localparam int LO = 2 * c;
        localparam int HI = 2 * c + 1;

        logic  older_hi;
        logic  lock_v;
        logic  lock_hi;
        logic  arb_hi;
        logic  sel_hi;
        logic  valid;
        logic  fire;
        task_t src;

        // Once offered without acceptance, the choice is frozen so the op stays stable.
        assign arb_hi = ready[HI] && (!ready[LO] || older_hi);
        assign sel_hi = lock_v ? lock_hi : arb_hi;
        assign valid  = ready[LO] || ready[HI];
        assign fire   = valid && bus.fu_issue_ready[c];
        assign clr[LO] = fire && !sel_hi;
        assign clr[HI] = fire && sel_hi;
        assign src    = sel_hi ? ent[HI] : ent[LO];

        assign bus.fu_issue_valid[c]        = valid;
        assign bus.fu_issue_op[c].opcode     = src.opcode;
        assign bus.fu_issue_op[c].src1_value = src.src1_value;
        assign bus.fu_issue_op[c].src2_value = src.src2_value;
        assign bus.fu_issue_op[c].imm        = src.imm;
        assign bus.fu_issue_op[c].tag        = sel_hi ? RS_tag_type'(HI) : RS_tag_type'(LO);

        // older_hi set means the upper entry of the pair was dispatched first.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                older_hi <= 1'b0;
                lock_v   <= 1'b0;
                lock_hi  <= 1'b0;
            end else begin
                if (disp_en[LO])
                    older_hi <= 1'b1;
                else if (disp_en[HI])
                    older_hi <= 1'b0;
                lock_v  <= valid && !bus.fu_issue_ready[c];
                lock_hi <= sel_hi;
            end
        end
    end

endmodule

// File: tb/tb_rs_bank.sv
// tb/tb_rs_bank.sv - directed self-checking bench for rs_bank
module tb_rs_bank;
    import cpu_types::*;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [5:0] rs_busy;
    int         n_run  = 0;
    int         n_fail = 0;

    localparam opcode_t OP_STORE = 6'h30;
    localparam opcode_t OP_LOAD  = 6'h20;
    localparam opcode_t OP_ALU   = 6'h10;

    always #5 CLK = ~CLK;

    rs_bank_if #(.XLEN(32)) bus ();

    rs_bank #(.XLEN(32), .NUM_RS(6)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .bus     (bus),
        .rs_busy (rs_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic task_t mk(input opcode_t op,
                                 input RS_tag_type t1, input logic [31:0] v1, input logic ok1,
                                 input RS_tag_type t2, input logic [31:0] v2, input logic ok2,
                                 input logic [31:0] imm);
        task_t t;
        t.opcode     = op;
        t.src1_tag   = t1;
        t.src1_value = v1;
        t.src1_valid = ok1;
        t.src2_tag   = t2;
        t.src2_value = v2;
        t.src2_valid = ok2;
        t.imm        = imm;
        return t;
    endfunction

    task automatic dispatch(input RS_tag_type dst, input task_t t);
        bus.DISPATCH_TASK = t;
        bus.dest_rs       = dst;
    endtask

    task automatic cdb(input logic v, input RS_tag_type tag, input logic [31:0] val);
        bus.cdb_valid = v;
        bus.cdb_tag   = tag;
        bus.cdb_value = val;
    endtask

    initial begin
        RST_N              = 1'b0;
        bus.DISPATCH_TASK  = '0;
        bus.dest_rs        = INVALID;
        bus.fu_issue_ready = 3'b000;
        cdb(1'b0, 3'd0, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        check("reset_busy", rs_busy, 6'b000000);
        check("reset_valid", bus.fu_issue_valid, 3'b000);
        check("reset_err", bus.dispatch_err, 1'b0);
        RST_N = 1'b1;

        // ALU_1 with operands already valid
        dispatch(ALU_1, mk(OP_ALU, 3'd0, 32'd5, 1'b1, 3'd0, 32'd7, 1'b1, 32'h100));
        step();
        bus.dest_rs = INVALID;
        check("alu_busy", rs_busy, 6'b010000);
        check("alu_valid", bus.fu_issue_valid, 3'b100);
        check("alu_src1", bus.fu_issue_op[CLS_ALU].src1_value, 32'd5);
        check("alu_src2", bus.fu_issue_op[CLS_ALU].src2_value, 32'd7);
        check("alu_imm", bus.fu_issue_op[CLS_ALU].imm, 32'h100);
        check("alu_tag", bus.fu_issue_op[CLS_ALU].tag, ALU_1);
        bus.fu_issue_ready = 3'b100;
        step();
        bus.fu_issue_ready = 3'b000;
        check("alu_clear", rs_busy, 6'b000000);
        check("alu_valid_off", bus.fu_issue_valid, 3'b000);

        // LOAD_1 waiting on ALU_2, woken 3 cycles later
        dispatch(LOAD_1, mk(OP_LOAD, ALU_2, 32'h0, 1'b0, 3'd0, 32'h10, 1'b1, 32'h4));
        step();
        bus.dest_rs = INVALID;
        check("ld_busy", rs_busy, 6'b000100);
        check("ld_wait", bus.fu_issue_valid, 3'b000);
        step();
        step();
        cdb(1'b1, ALU_2, 32'h1234);
        check("ld_wait_cdb", bus.fu_issue_valid, 3'b000);
        step();
        cdb(1'b0, 3'd0, 32'h0);
        check("ld_wake", bus.fu_issue_valid, 3'b010);
        check("ld_src1", bus.fu_issue_op[CLS_LOAD].src1_value, 32'h1234);
        check("ld_src2", bus.fu_issue_op[CLS_LOAD].src2_value, 32'h10);
        check("ld_tag", bus.fu_issue_op[CLS_LOAD].tag, LOAD_1);
        bus.fu_issue_ready = 3'b010;
        step();
        bus.fu_issue_ready = 3'b000;
        check("ld_clear", rs_busy, 6'b000000);

        // STORE_2 dispatched alongside its producer's broadcast
        dispatch(STORE_2, mk(OP_STORE, 3'd0, 32'd3, 1'b1, ALU_1, 32'h0, 1'b0, 32'h0));
        cdb(1'b1, ALU_1, 32'd9);
        step();
        bus.dest_rs = INVALID;
        cdb(1'b0, 3'd0, 32'h0);
        check("byp_valid", bus.fu_issue_valid, 3'b001);
        check("byp_src1", bus.fu_issue_op[CLS_STORE].src1_value, 32'd3);
        check("byp_src2", bus.fu_issue_op[CLS_STORE].src2_value, 32'd9);
        check("byp_tag", bus.fu_issue_op[CLS_STORE].tag, STORE_2);
        bus.fu_issue_ready = 3'b001;
        step();
        bus.fu_issue_ready = 3'b000;
        check("byp_clear", rs_busy, 6'b000000);

        // STORE_1 then STORE_2, ready held low 2 cycles; ALU opcode into store slots
        dispatch(STORE_1, mk(OP_ALU, 3'd0, 32'd11, 1'b1, 3'd0, 32'd12, 1'b1, 32'h0));
        step();
        dispatch(STORE_2, mk(OP_ALU, 3'd0, 32'd21, 1'b1, 3'd0, 32'd22, 1'b1, 32'h0));
        step();
        bus.dest_rs = INVALID;
        check("ord_busy", rs_busy, 6'b000011);
        check("ord_first_tag", bus.fu_issue_op[CLS_STORE].tag, STORE_1);
        check("ord_opcode", bus.fu_issue_op[CLS_STORE].opcode, OP_ALU);
        step();
        check("ord_hold_tag", bus.fu_issue_op[CLS_STORE].tag, STORE_1);
        check("ord_hold_src1", bus.fu_issue_op[CLS_STORE].src1_value, 32'd11);
        bus.fu_issue_ready = 3'b001;
        step();
        check("ord_after1_busy", rs_busy, 6'b000010);
        check("ord_second_tag", bus.fu_issue_op[CLS_STORE].tag, STORE_2);
        check("ord_second_src1", bus.fu_issue_op[CLS_STORE].src1_value, 32'd21);
        step();
        bus.fu_issue_ready = 3'b000;
        check("ord_clear", rs_busy, 6'b000000);

        // STORE_2 older than STORE_1, both woken by one broadcast
        dispatch(STORE_2, mk(OP_STORE, LOAD_2, 32'h0, 1'b0, 3'd0, 32'd22, 1'b1, 32'h0));
        step();
        dispatch(STORE_1, mk(OP_STORE, LOAD_2, 32'h0, 1'b0, 3'd0, 32'd12, 1'b1, 32'h0));
        step();
        bus.dest_rs = INVALID;
        check("age_wait", bus.fu_issue_valid, 3'b000);
        cdb(1'b1, LOAD_2, 32'h77);
        step();
        cdb(1'b0, 3'd0, 32'h0);
        check("age_first_tag", bus.fu_issue_op[CLS_STORE].tag, STORE_2);
        check("age_first_src1", bus.fu_issue_op[CLS_STORE].src1_value, 32'h77);
        bus.fu_issue_ready = 3'b001;
        step();
        check("age_second_tag", bus.fu_issue_op[CLS_STORE].tag, STORE_1);
        check("age_second_src2", bus.fu_issue_op[CLS_STORE].src2_value, 32'd12);
        step();
        bus.fu_issue_ready = 3'b000;
        check("age_clear", rs_busy, 6'b000000);

        // Dispatch to busy LOAD_2 is rejected
        dispatch(LOAD_2, mk(OP_LOAD, ALU_2, 32'h0, 1'b0, 3'd0, 32'h20, 1'b1, 32'h0));
        step();
        check("rej_busy", rs_busy, 6'b001000);
        check("rej_no_err", bus.dispatch_err, 1'b0);
        dispatch(LOAD_2, mk(OP_LOAD, 3'd0, 32'hAA, 1'b1, 3'd0, 32'hBB, 1'b1, 32'h0));
        step();
        bus.dest_rs = INVALID;
        check("rej_err", bus.dispatch_err, 1'b1);
        check("rej_keep_busy", rs_busy, 6'b001000);
        check("rej_still_wait", bus.fu_issue_valid, 3'b000);
        step();
        check("rej_err_pulse", bus.dispatch_err, 1'b0);
        cdb(1'b1, ALU_2, 32'h55);
        step();
        cdb(1'b0, 3'd0, 32'h0);
        check("rej_src1", bus.fu_issue_op[CLS_LOAD].src1_value, 32'h55);
        check("rej_src2", bus.fu_issue_op[CLS_LOAD].src2_value, 32'h20);
        bus.fu_issue_ready = 3'b010;
        dispatch(LOAD_2, mk(OP_LOAD, 3'd0, 32'hAA, 1'b1, 3'd0, 32'hBB, 1'b1, 32'h0));
        step();
        bus.dest_rs        = INVALID;
        bus.fu_issue_ready = 3'b000;
        check("rej_issue_err", bus.dispatch_err, 1'b1);
        check("rej_issue_busy", rs_busy, 6'b000000);

        // Reset with four entries occupied
        dispatch(STORE_1, mk(OP_STORE, 3'd0, 32'd1, 1'b1, 3'd0, 32'd2, 1'b1, 32'h0));
        step();
        dispatch(LOAD_1, mk(OP_LOAD, 3'd0, 32'd3, 1'b1, 3'd0, 32'd4, 1'b1, 32'h0));
        step();
        dispatch(ALU_1, mk(OP_ALU, 3'd0, 32'd5, 1'b1, 3'd0, 32'd6, 1'b1, 32'h0));
        step();
        dispatch(ALU_2, mk(OP_ALU, 3'd0, 32'd7, 1'b1, 3'd0, 32'd8, 1'b1, 32'h0));
        step();
        bus.dest_rs = INVALID;
        check("rst_pre_busy", rs_busy, 6'b110101);
        check("rst_pre_valid", bus.fu_issue_valid, 3'b111);
        #2;
        RST_N = 1'b0;
        #1;
        check("rst_busy", rs_busy, 6'b000000);
        check("rst_valid", bus.fu_issue_valid, 3'b000);
        @(posedge CLK);
        #1;
        RST_N              = 1'b1;
        bus.fu_issue_ready = 3'b111;
        check("rst_release_valid", bus.fu_issue_valid, 3'b000);
        step();
        check("rst_after_valid", bus.fu_issue_valid, 3'b000);
        check("rst_after_busy", rs_busy, 6'b000000);
        bus.fu_issue_ready = 3'b000;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
